// File: rtl/deinterleaver_if.sv
// Byte-stream bundle between the channel side, the deinterleaver and the RS decoder.
// Handshake: a byte moves when the source's rdy and the sink's acpt are both high on a posedge;
// rdy never waits for acpt, and the source holds data steady until that byte is taken.
interface deinterleaver_if #(
    parameter int WIDTH = 8
);
    logic             di_rdy;
    logic             di_acpt;
    logic [WIDTH-1:0] di_data;
    logic             do_rdy;
    logic             do_acpt;
    logic [WIDTH-1:0] do_data;

    modport master (
        output di_rdy, di_data, do_acpt,
        input  di_acpt, do_rdy, do_data
    );

    modport slave (
        input  di_rdy, di_data, do_acpt,
        output di_acpt, do_rdy, do_data
    );
endinterface

// File: rtl/deinterleaver.sv
// Convolutional deinterleaver: branch b delays its bytes by (BRANCHES-1-b)*M branch slots.
// Optional sync-lock commutator realignment is built when DEINT_SYNC_LOCK_EN is defined.
module deinterleaver #(
    parameter int                WIDTH    = 8,
    parameter int                BRANCHES = 12,
    parameter int                M        = 17,
    parameter int                PKT_LEN  = 204
`ifdef DEINT_SYNC_LOCK_EN
    ,
    parameter logic [WIDTH-1:0]  SYNC_A   = 8'h47,
    parameter logic [WIDTH-1:0]  SYNC_B   = 8'hB8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    deinterleaver_if.slave        bus,
    output logic                  lock,
    output logic [1:0]            o_dbg_state
);

    localparam int CELLS = PKT_LEN * (BRANCHES - 1) / 2;
    localparam int AW    = $clog2(CELLS);
    localparam int PW    = $clog2(M * (BRANCHES - 1) + 1);
    localparam int BW    = $clog2(BRANCHES);

    function automatic int branch_depth(input int b);
        return M * (BRANCHES - 1 - b);
    endfunction

    // Branches are packed back to back; the zero-depth branch gets base 0 so its address stays in range.
    function automatic int branch_base(input int b);
        if (branch_depth(b) == 0) return 0;
        return M * ((b * (2 * BRANCHES - 1 - b)) / 2);
    endfunction

    logic [WIDTH-1:0] r_mem [CELLS];
    logic [PW-1:0]    r_wptr [BRANCHES];
    logic [BRANCHES-1:0] r_full;
    logic [BW-1:0]    r_branch;
    logic             r_do_rdy;
    logic [WIDTH-1:0] r_do_data;

    logic [AW-1:0]    w_base_tab  [BRANCHES];
    logic [PW-1:0]    w_depth_tab [BRANCHES];
    logic [BW-1:0]    w_sel_branch;
    logic [PW-1:0]    w_depth;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_out_byte;
    logic             w_di_acpt;
    logic             w_accept;

    for (genvar g = 0; g < BRANCHES; g++) begin : g_tab
        assign w_base_tab[g]  = AW'(branch_base(g));
        assign w_depth_tab[g] = PW'(branch_depth(g));
    end

    assign w_di_acpt   = enable & ~reset & (~r_do_rdy | bus.do_acpt);
    assign w_accept    = bus.di_rdy & w_di_acpt;
    assign bus.di_acpt = w_di_acpt;
    assign bus.do_rdy  = r_do_rdy;
    assign bus.do_data = r_do_data;

    assign w_depth = w_depth_tab[w_sel_branch];
    assign w_addr  = w_base_tab[w_sel_branch] + AW'(r_wptr[w_sel_branch]);

    always_comb begin
        w_out_byte = '0;
        if (w_depth == '0)
            w_out_byte = bus.di_data;
        else if (r_full[w_sel_branch])
            w_out_byte = r_mem[w_addr];
    end

    // The cell read this cycle is the one overwritten, so each branch acts as a circular FIFO.
    always_ff @(posedge clk) begin
        if (w_accept && (w_depth != '0))
            r_mem[w_addr] <= bus.di_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BRANCHES; i++)
                r_wptr[i] <= '0;
            r_full   <= '0;
            r_branch <= '0;
        end else if (w_accept) begin
            if (w_depth != '0) begin
                if (r_wptr[w_sel_branch] == w_depth - PW'(1)) begin
                    r_wptr[w_sel_branch] <= '0;
                    r_full[w_sel_branch] <= 1'b1;
                end else begin
                    r_wptr[w_sel_branch] <= r_wptr[w_sel_branch] + PW'(1);
                end
            end
            r_branch <= (w_sel_branch == BW'(BRANCHES - 1)) ? '0 : w_sel_branch + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_do_rdy  <= 1'b0;
            r_do_data <= '0;
        end else if (w_accept) begin
            r_do_rdy  <= 1'b1;
            r_do_data <= w_out_byte;
        end else if (bus.do_acpt) begin
            r_do_rdy  <= 1'b0;
        end
    end

`ifdef DEINT_SYNC_LOCK_EN
    localparam int SW = $clog2(PKT_LEN);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCKED = 2'd2
    } sync_state_t;

    sync_state_t r_state, w_next_state;
    logic [SW-1:0] r_pos, w_next_pos;
    logic [1:0]    r_hits, w_next_hits;
    logic [1:0]    r_misses, w_next_misses;
    logic          w_is_sync;

    assign w_is_sync = (bus.di_data == SYNC_A) || (bus.di_data == SYNC_B);

    // While hunting, a sync byte is steered onto branch 0 to realign the commutator.
    assign w_sel_branch = ((r_state == S_HUNT) && w_is_sync) ? '0 : r_branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_HUNT;
            r_pos    <= '0;
            r_hits   <= '0;
            r_misses <= '0;
        end else if (w_accept) begin
            r_state  <= w_next_state;
            r_pos    <= w_next_pos;
            r_hits   <= w_next_hits;
            r_misses <= w_next_misses;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_hits   = r_hits;
        w_next_misses = r_misses;
        w_next_pos    = (r_pos == SW'(PKT_LEN - 1)) ? '0 : r_pos + SW'(1);
        case (r_state)
            S_HUNT: begin
                if (w_is_sync) begin
                    w_next_state = S_CHECK;
                    w_next_pos   = SW'(1);
                    w_next_hits  = 2'd1;
                end
            end
            S_CHECK: begin
                if (r_pos == '0) begin
                    if (!w_is_sync) begin
                        w_next_state = S_HUNT;
                    end else begin
                        w_next_hits = r_hits + 2'd1;
                        if (r_hits == 2'd2) begin
                            w_next_state  = S_LOCKED;
                            w_next_misses = '0;
                        end
                    end
                end
            end
            S_LOCKED: begin
                if (r_pos == '0) begin
                    if (w_is_sync) begin
                        w_next_misses = '0;
                    end else begin
                        w_next_misses = r_misses + 2'd1;
                        if (r_misses == 2'd2)
                            w_next_state = S_HUNT;
                    end
                end
            end
            default: w_next_state = S_HUNT;
        endcase
    end

    always_comb begin
        lock        = (r_state == S_LOCKED);
        o_dbg_state = r_state;
    end
`else
    assign w_sel_branch = r_branch;

    // Without sync tracking the commutator free-runs and the stream is always treated as locked.
    always_comb begin
        lock        = 1'b1;
        o_dbg_state = 2'd2;
    end
`endif

endmodule
